// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for a multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback, drives datapath selects and strobes, counts retired instructions.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [3:0]       state,
  output logic             bad_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_J_EX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_instr_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_instr_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_retire)
        r_instr_count <= r_instr_count + 1'b1;
    end
  end

  always_comb begin
    w_state_next  = S_FETCH;
    w_retire      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    bad_op        = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        ir_write     = mem_ready;
        pc_write     = mem_ready;
        w_state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_RTYPE:     w_state_next = S_RTYPE_EX;
          OP_BEQ:       w_state_next = S_BEQ_EX;
          OP_ADDI:      w_state_next = S_ADDI_EX;
          OP_J:         w_state_next = S_J_EX;
          default: begin
            w_state_next = S_FETCH;
            bad_op       = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        w_state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read     = 1'b1;
        i_or_d       = 1'b1;
        w_state_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEMWR: begin
        mem_write    = 1'b1;
        i_or_d       = 1'b1;
        w_retire     = mem_ready;
        w_state_next = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPE_EX: begin
        alu_src_a    = 1'b1;
        alu_op       = 2'b10;
        w_state_next = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_retire  = 1'b1;
      end
      S_BEQ_EX: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        w_retire      = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        w_state_next = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
      end
      S_J_EX: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        w_retire  = 1'b1;
      end
      default: w_state_next = S_FETCH;
    endcase

    // Reset suppresses every side effect in the cycle it is applied.
    if (rst) begin
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      bad_op        = 1'b0;
    end
  end

  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl: one vector per clock cycle,
// plus a hand-written MEMRD stall sequence.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_source, alu_op, alu_src_b;
  logic        alu_src_a, reg_write, reg_dst, mem_to_reg, bad_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .state(state), .bad_op(bad_op),
    .instr_count(instr_count)
  );

  // Output bundle: {mr,mw,iod,irw,pcw,pcc,pcs[2],aop[2],asa,asb[2],rw,rd,m2r,bad}
  function automatic logic [17:0] mk(input logic mr, mw, iod, irw, pcw, pcc,
                                     input logic [1:0] pcs, aop,
                                     input logic asa, input logic [1:0] asb,
                                     input logic rw, rd, m2r, bad);
    return {mr, mw, iod, irw, pcw, pcc, pcs, aop, asa, asb, rw, rd, m2r, bad};
  endfunction

  function automatic logic [17:0] act();
    return {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
            pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
            mem_to_reg, bad_op};
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] outs;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[36];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    rst = v.rst; opcode = v.op; mem_ready = v.mr;
    #1;
    check($sformatf("v%0d_state", idx), {28'd0, state}, {28'd0, v.st});
    check($sformatf("v%0d_outs", idx), {14'd0, act()}, {14'd0, v.outs});
    check($sformatf("v%0d_count", idx), instr_count, v.cnt);
    $display("vec %0d rst=%0b op=%h mr=%0b state=%0d outs=%h cnt=%0d",
             idx, v.rst, v.op, v.mr, state, act(), instr_count);
  endtask

  logic [17:0] o_f0, o_f1, o_f_rst, o_dec, o_adr, o_rd, o_wb, o_wr;
  logic [17:0] o_rex, o_rwb, o_beq, o_aex, o_awb, o_j, o_bad;

  initial begin
    //            mr mw io ir pw pc pcs    aop    asa asb   rw rd m2 bad
    o_f0    = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0, 0);
    o_f1    = mk(1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0, 0);
    o_f_rst = o_f0;
    o_dec   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 0, 0, 0);
    o_bad   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 0, 0, 1);
    o_adr   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0, 0);
    o_rd    = mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    o_wb    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 1, 0);
    o_wr    = mk(0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    o_rex   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 2'b00, 0, 0, 0, 0);
    o_rwb   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 1, 0, 0);
    o_beq   = mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 1, 2'b00, 0, 0, 0, 0);
    o_aex   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0, 0);
    o_awb   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0, 0);
    o_j     = mk(0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0, 0);

    //          rst  op     mr  st  outs      cnt
    vecs[0]  = '{1, 6'h23, 1,  0, o_f_rst, 0};  // strobes masked in reset
    // lw, mem_ready=1 throughout (mem_ready=0 in MEMWB is ignored)
    vecs[1]  = '{0, 6'h23, 1,  0, o_f1,  0};
    vecs[2]  = '{0, 6'h23, 1,  1, o_dec, 0};
    vecs[3]  = '{0, 6'h23, 1,  2, o_adr, 0};
    vecs[4]  = '{0, 6'h23, 1,  3, o_rd,  0};
    vecs[5]  = '{0, 6'h23, 0,  4, o_wb,  0};
    // sw, MEMWR stalled 3 cycles
    vecs[6]  = '{0, 6'h2B, 1,  0, o_f1,  1};
    vecs[7]  = '{0, 6'h2B, 0,  1, o_dec, 1};
    vecs[8]  = '{0, 6'h2B, 1,  2, o_adr, 1};
    vecs[9]  = '{0, 6'h2B, 0,  5, o_wr,  1};
    vecs[10] = '{0, 6'h2B, 0,  5, o_wr,  1};
    vecs[11] = '{0, 6'h2B, 0,  5, o_wr,  1};
    vecs[12] = '{0, 6'h2B, 1,  5, o_wr,  1};
    // FETCH stall 2 cycles, then R-type
    vecs[13] = '{0, 6'h00, 0,  0, o_f0,  2};
    vecs[14] = '{0, 6'h00, 0,  0, o_f0,  2};
    vecs[15] = '{0, 6'h00, 1,  0, o_f1,  2};
    vecs[16] = '{0, 6'h00, 0,  1, o_dec, 2};
    vecs[17] = '{0, 6'h00, 1,  6, o_rex, 2};
    vecs[18] = '{0, 6'h00, 1,  7, o_rwb, 2};
    // beq
    vecs[19] = '{0, 6'h04, 1,  0, o_f1,  3};
    vecs[20] = '{0, 6'h04, 1,  1, o_dec, 3};
    vecs[21] = '{0, 6'h04, 1,  8, o_beq, 3};
    // unsupported opcode
    vecs[22] = '{0, 6'h3F, 1,  0, o_f1,  4};
    vecs[23] = '{0, 6'h3F, 1,  1, o_bad, 4};
    // addi
    vecs[24] = '{0, 6'h08, 1,  0, o_f1,  4};
    vecs[25] = '{0, 6'h08, 1,  1, o_dec, 4};
    vecs[26] = '{0, 6'h08, 1,  9, o_aex, 4};
    vecs[27] = '{0, 6'h08, 1, 10, o_awb, 4};
    // lw interrupted by reset in MEMRD
    vecs[28] = '{0, 6'h23, 1,  0, o_f1,  5};
    vecs[29] = '{0, 6'h23, 1,  1, o_dec, 5};
    vecs[30] = '{0, 6'h23, 1,  2, o_adr, 5};
    vecs[31] = '{1, 6'h23, 1,  3, o_rd,  5};
    // j after reset
    vecs[32] = '{0, 6'h02, 1,  0, o_f1,  0};
    vecs[33] = '{0, 6'h02, 1,  1, o_dec, 0};
    vecs[34] = '{0, 6'h02, 1, 11, o_j,   0};
    vecs[35] = '{0, 6'h00, 0,  0, o_f0,  1};

    rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 36; i++)
      apply(i, vecs[i]);

    // Hand sequence: lw with MEMRD stalled, bounded wait for MEMWB.
    begin
      int n;
      @(negedge clk); opcode = 6'h23; mem_ready = 1'b1;   // FETCH
      @(negedge clk);                                      // DECODE
      @(negedge clk);                                      // MEMADR
      @(negedge clk); mem_ready = 1'b0; #1;                // MEMRD stalled
      check("memrd_stall_state", {28'd0, state}, 32'd3);
      check("memrd_stall_rw", {31'd0, reg_write}, 32'd0);
      $display("stall state=%0d reg_write=%0b", state, reg_write);
      @(negedge clk); #1;
      check("memrd_stall2_state", {28'd0, state}, 32'd3);
      mem_ready = 1'b1;
      n = 0;
      while (state != 4'd4 && n < 10) begin
        @(negedge clk); #1; n++;
      end
      check("memwb_reached", {28'd0, state}, 32'd4);
      check("memwb_rw_m2r", {30'd0, reg_write, mem_to_reg}, 32'd3);
      $display("memwb after %0d cycles state=%0d", n, state);
      @(negedge clk); #1;
      check("lw_retired", instr_count, 32'd2);
      check("back_to_fetch", {28'd0, state}, 32'd0);
      $display("after lw state=%0d cnt=%0d", state, instr_count);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for a multicycle MIPS core; initiator side of the datapath primitives (register file, ALU/ALU control, data/instruction memory, PC and IR registers).
- Sequences fetch/decode/execute/memory/writeback and drives every datapath select and write strobe.
- Issues memory requests over a read/write-strobe plus mem_ready handshake, so slow memories can stall it.
- Also counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- opcode  in  6  instr[31:26] from IR.
- mem_ready  in  1  memory completes current request this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- i_or_d  out  1  address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (AND done in datapath).
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- alu_op  out  2  to ALU control: 00 add, 01 sub, 10 funct.
- alu_src_a  out  1  0=PC, 1=reg A.
- alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALUOut, 1=MDR.
- state  out  4  current state (debug).
- bad_op  out  1  one-cycle pulse on unsupported opcode.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, RTYPE_WB=7, BEQ_EX=8, ADDI_EX=9, ADDI_WB=10, J_EX=11.
- Encodings 12-15 go to FETCH next cycle; outputs in those states are all 0.
- Reset: state=FETCH, instr_count=0, bad_op=0.
- While rst=1: all write strobes (pc_write, pc_write_cond, ir_write, reg_write, mem_write) are forced to 0.
- Outputs are combinational from state; unlisted outputs are 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready (Mealy).
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: 0x23/0x2B -> MEMADR; 0x00 -> RTYPE_EX; 0x04 -> BEQ_EX; 0x08 -> ADDI_EX; 0x02 -> J_EX.
  - Any other opcode: go to FETCH and assert bad_op for that DECODE cycle.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next: 0x23 -> MEMRD; otherwise MEMWR.
- MEMRD: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; retire; next FETCH.
- MEMWR:
  - Outputs: mem_write=1, i_or_d=1, held stable until mem_ready=1.
  - On mem_ready=1: retire, next FETCH.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10; next RTYPE_WB.
- RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0; retire; next FETCH.
- BEQ_EX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; retire; next FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00; next ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; retire; next FETCH.
- J_EX: pc_write=1, pc_source=10; retire; next FETCH.
- Retire: instr_count increments by 1 on the clock edge leaving a retire state.
  - Wraps modulo 2^CNT_W.
  - bad_op instructions are not counted.
- Cycle counts with mem_ready always 1: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- opcode is sampled only in DECODE and MEMADR; IR is stable there.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Reset mid-instruction (any state): the next state is FETCH, the instruction is not counted, and no strobe fires in the reset cycle.

Test Plan:
- lw (0x23), mem_ready=1 constant -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_count=1.
- sw (0x2B), mem_ready low for 3 cycles in MEMWR -> mem_write=1 and i_or_d=1 held for 4 cycles; next state 0; total 7 cycles; instr_count +1.
- FETCH with mem_ready=0 for 2 cycles, then 1 -> ir_write and pc_write are 0, 0, 1; DECODE entered on the following edge.
- R-type (0x00) then beq (0x04) -> RTYPE_EX shows alu_op=10; RTYPE_WB shows reg_dst=1; BEQ_EX shows pc_write_cond=1, pc_source=01, alu_op=01; instr_count=2 after 7 cycles.
- Unsupported opcode 0x3F -> bad_op=1 for exactly one cycle in DECODE; state returns to 0; instr_count unchanged.
- rst asserted during MEMRD with mem_ready=1 -> reg_write never asserted; state=0 and instr_count=0 after the edge; j (0x02) afterwards completes in 3 cycles with pc_source=10.
